// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the 256x8 data memory between the stage-4 pipeline port and a host/loader port.
// Define DMEM_ARB_STATS_EN to add the stall / host-grant statistics counters.
module dmem_arbiter #(
    parameter int RD_LAT    = 1,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_rd,
    input  logic        pipe_wr,
    input  logic [7:0]  pipe_addr,
    input  logic [7:0]  pipe_wdata,
    output logic [7:0]  pipe_rdata,
    output logic        pipe_stall,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [7:0]  host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_gnt,
    output logic        host_rvalid,
    output logic [7:0]  host_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
`ifdef DMEM_ARB_STATS_EN
    input  logic        stat_clr,
    output logic [15:0] stat_stall_cnt,
    output logic [15:0] stat_host_cnt,
`endif
    input  logic [7:0]  mem_rdata
);

    typedef enum logic {S_PIPE, S_HOST} state_t;

    localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
    localparam logic [3:0] BURST_MAX_C = 4'(BURST_MAX);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]  run_cnt_q, run_cnt_d;
    logic [RD_LAT-1:0] tag_vld_q, tag_host_q;
    logic [7:0]  pipe_rdata_q;

    logic pipe_req, host_win, host_go, pipe_go;
    logic tail_vld, tail_host, pipe_ret;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        pipe_req = pipe_rd | pipe_wr;
        host_win = host_req;
        if (host_req && pipe_req) begin
            if (state_q == S_PIPE) host_win = (wait_cnt_q >= MAX_WAIT_C);
            else                   host_win = (run_cnt_q < BURST_MAX_C);
        end
        // Combinational grants are forced off while reset is asserted.
        host_go = host_win & rst;
        pipe_go = pipe_req & ~host_win & rst;

        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        if (host_go) begin
            mem_read  = ~host_we;
            mem_write = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (pipe_go) begin
            mem_read  = pipe_rd & ~pipe_wr;
            mem_write = pipe_wr;
            mem_addr  = pipe_addr;
            mem_wdata = pipe_wdata;
        end
        host_gnt   = host_go;
        pipe_stall = pipe_req & rst & ~pipe_go;

        state_d = host_go ? S_HOST : S_PIPE;

        wait_cnt_d = wait_cnt_q;
        if (host_go)                            wait_cnt_d = 4'd0;
        else if (host_req && wait_cnt_q != 4'hF) wait_cnt_d = wait_cnt_q + 4'd1;

        run_cnt_d = 4'd0;
        if (host_go) run_cnt_d = (run_cnt_q == 4'hF) ? run_cnt_q : run_cnt_q + 4'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_PIPE;
            wait_cnt_q <= 4'd0;
            run_cnt_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            run_cnt_q  <= run_cnt_d;
        end
    end

    // Tag pipeline: {valid, owner} for each granted read, matched to the memory read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld_q  <= '0;
            tag_host_q <= '0;
        end else begin
            tag_vld_q[0]  <= mem_read;
            tag_host_q[0] <= host_go;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_host_q[i] <= tag_host_q[i-1];
            end
        end
    end

    assign tail_vld  = tag_vld_q[RD_LAT-1];
    assign tail_host = tag_host_q[RD_LAT-1];
    assign pipe_ret  = tail_vld & ~tail_host;

    assign host_rvalid = tail_vld & tail_host;
    assign host_rdata  = host_rvalid ? mem_rdata : 8'h00;
    assign pipe_rdata  = pipe_ret ? mem_rdata : pipe_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          pipe_rdata_q <= 8'h00;
        else if (pipe_ret) pipe_rdata_q <= mem_rdata;
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_cnt_q, host_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 16'h0000;
            host_cnt_q  <= 16'h0000;
        end else if (stat_clr) begin
            stall_cnt_q <= 16'h0000;
            host_cnt_q  <= 16'h0000;
        end else begin
            if (pipe_stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (host_go && host_cnt_q != 16'hFFFF)     host_cnt_q  <= host_cnt_q + 16'd1;
        end
    end

    assign stat_stall_cnt = stall_cnt_q;
    assign stat_host_cnt  = host_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model (ownership rules, counters, return queue, shadow memory).
module tb_dmem_arbiter;

    localparam int RD_LAT    = 1;
    localparam int MAX_WAIT  = 4;
    localparam int BURST_MAX = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       pipe_rd, pipe_wr;
    logic [7:0] pipe_addr, pipe_wdata, pipe_rdata;
    logic       pipe_stall;
    logic       host_req, host_we;
    logic [7:0] host_addr, host_wdata;
    logic       host_gnt, host_rvalid;
    logic [7:0] host_rdata;
    logic       mem_read, mem_write;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .rst(rst),
        .pipe_rd(pipe_rd), .pipe_wr(pipe_wr), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
        .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Memory environment: synchronous 256x8 with RD_LAT cycles of read latency.
    logic [7:0] env_mem [256]    = '{default: 8'h00};
    logic [7:0] rd_pipe [RD_LAT] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_write) env_mem[mem_addr] <= mem_wdata;
        rd_pipe[0] <= mem_read ? env_mem[mem_addr] : 8'h00;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct { int due; bit host; logic [7:0] data; } ret_t;
    ret_t       ret_q[$];
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    int         cyc = 0;
    bit         m_last_host = 0;
    int         m_wait = 0, m_run = 0;
    logic [7:0] m_prdata = 8'h00;
    bit         m_hg, m_pg;
    logic       obs_hg, obs_stall, obs_rv;
    logic [7:0] obs_hrd;

    task automatic drive_cycle(input logic prd, input logic pwr, input logic [7:0] pa, input logic [7:0] pd,
                               input logic hr, input logic hwe, input logic [7:0] ha, input logic [7:0] hd);
        bit preq, e_rd, e_wr, e_rv;
        logic [7:0] e_addr, e_wdata, e_hrd;
        ret_t r;
        @(negedge clk);
        rst = 1'b1;
        pipe_rd = prd; pipe_wr = pwr; pipe_addr = pa; pipe_wdata = pd;
        host_req = hr; host_we = hwe; host_addr = ha; host_wdata = hd;
        #1;
        preq = prd | pwr;
        if (preq && hr) m_hg = m_last_host ? (m_run < BURST_MAX) : (m_wait >= MAX_WAIT);
        else            m_hg = hr;
        m_pg = preq && !m_hg;
        e_rd = 0; e_wr = 0; e_addr = 8'h00; e_wdata = 8'h00;
        if (m_hg)      begin e_rd = !hwe; e_wr = hwe; e_addr = ha; e_wdata = hd; end
        else if (m_pg) begin e_wr = pwr; e_rd = !pwr; e_addr = pa; e_wdata = pd; end
        e_rv = 0; e_hrd = 8'h00;
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            r = ret_q.pop_front();
            if (r.host) begin e_rv = 1; e_hrd = r.data; end
            else m_prdata = r.data;
        end
        obs_hg = host_gnt; obs_stall = pipe_stall; obs_rv = host_rvalid; obs_hrd = host_rdata;
        check("host_gnt",    16'(host_gnt),    16'(m_hg));
        check("pipe_stall",  16'(pipe_stall),  16'(preq && !m_pg));
        check("mem_read",    16'(mem_read),    16'(e_rd));
        check("mem_write",   16'(mem_write),   16'(e_wr));
        check("mem_addr",    16'(mem_addr),    16'(e_addr));
        check("mem_wdata",   16'(mem_wdata),   16'(e_wdata));
        check("host_rvalid", 16'(host_rvalid), 16'(e_rv));
        if (e_rv) check("host_rdata", 16'(host_rdata), 16'(e_hrd));
        check("pipe_rdata",  16'(pipe_rdata),  16'(m_prdata));
        // commit this cycle's transaction to the model
        if (e_rd) ret_q.push_back('{cyc + RD_LAT, m_hg, ref_mem[e_addr]});
        if (e_wr) ref_mem[e_addr] = e_wdata;
        if (m_hg) begin
            m_wait = 0;
            m_run  = (m_run < 15) ? m_run + 1 : 15;
        end else begin
            if (hr) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
            m_run = 0;
        end
        m_last_host = m_hg;
        cyc++;
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst = 1'b0;
        pipe_rd = 0; pipe_wr = 0; host_req = 0; host_we = 0;
        pipe_addr = 8'h00; pipe_wdata = 8'h00; host_addr = 8'h00; host_wdata = 8'h00;
        #1;
        check("rst_host_gnt",    16'(host_gnt),    16'h0);
        check("rst_pipe_stall",  16'(pipe_stall),  16'h0);
        check("rst_mem_read",    16'(mem_read),    16'h0);
        check("rst_mem_write",   16'(mem_write),   16'h0);
        check("rst_mem_addr",    16'(mem_addr),    16'h0);
        check("rst_host_rvalid", 16'(host_rvalid), 16'h0);
        check("rst_host_rdata",  16'(host_rdata),  16'h0);
        check("rst_pipe_rdata",  16'(pipe_rdata),  16'h0);
        ret_q.delete();
        m_last_host = 0; m_wait = 0; m_run = 0; m_prdata = 8'h00;
        cyc++;
    endtask

    task automatic idle();
        drive_cycle(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    initial begin
        int refused, streak, max_streak, stalls, pulses;
        bit h_pend, h_we, p_pend, p_rd, p_wr;
        logic [7:0] h_addr, h_wd, p_addr, p_wd;

        rst = 1'b0;
        pipe_rd = 0; pipe_wr = 0; host_req = 0; host_we = 0;
        pipe_addr = 0; pipe_wdata = 0; host_addr = 0; host_wdata = 0;
        reset_cycle();
        reset_cycle();
        idle();
        idle();

        // Host write then read back
        drive_cycle(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'hA5);
        drive_cycle(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
        drive_cycle(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        check("host_rb_valid", 16'(obs_rv), 16'h1);
        check("host_rb_data",  16'(obs_hrd), 16'h00A5);

        // Starvation: pipeline reads every cycle, host held until granted
        reset_cycle();
        refused = 0; stalls = 0;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(1, 0, 8'h10, 8'h00, 1, 0, 8'h30, 8'h00);
            stalls += int'(obs_stall);
            if (obs_hg) break;
            refused++;
        end
        check("wait_refused", 16'(refused), 16'(MAX_WAIT));
        check("wait_stalls",  16'(stalls),  16'h1);
        idle();
        idle();

        // Burst limit: host requests continuously, pipe_wr held
        reset_cycle();
        streak = 0; max_streak = 0; stalls = 0;
        for (int i = 0; i < 2 * (BURST_MAX + MAX_WAIT + 2); i++) begin
            drive_cycle(0, 1, 8'h40, 8'h5A, 1, 1, 8'h41, 8'hC3);
            stalls += int'(obs_stall);
            streak = obs_hg ? streak + 1 : 0;
            if (streak > max_streak) max_streak = streak;
        end
        check("burst_max_streak", 16'(max_streak), 16'(BURST_MAX));
        check("burst_stalls", 16'(stalls), 16'(2 * BURST_MAX));
        idle();

        // Interleaved owners: preload, then pipe/host/pipe reads back to back
        drive_cycle(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h11);
        drive_cycle(0, 0, 8'h00, 8'h00, 1, 1, 8'h21, 8'h22);
        drive_cycle(0, 0, 8'h00, 8'h00, 1, 1, 8'h22, 8'h33);
        pulses = 0;
        drive_cycle(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
        drive_cycle(0, 0, 8'h00, 8'h00, 1, 0, 8'h21, 8'h00);
        check("il_pipe_20", 16'(pipe_rdata), 16'h0011);
        drive_cycle(1, 0, 8'h22, 8'h00, 0, 0, 8'h00, 8'h00);
        pulses += int'(obs_rv);
        check("il_host_21", 16'(obs_hrd), 16'h0022);
        drive_cycle(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        pulses += int'(obs_rv);
        check("il_pipe_22", 16'(pipe_rdata), 16'h0033);
        idle();
        pulses += int'(obs_rv);
        check("il_host_pulses", 16'(pulses), 16'h1);

        // Host read in flight across a reset
        drive_cycle(0, 0, 8'h00, 8'h00, 1, 0, 8'h21, 8'h00);
        reset_cycle();
        idle();
        check("rst_flight_no_rv", 16'(obs_rv), 16'h0);
        drive_cycle(1, 0, 8'h20, 8'h00, 1, 0, 8'h21, 8'h00);
        check("post_rst_pipe_first", 16'(obs_hg), 16'h0);
        idle();

        // Simultaneous rd and wr is a write with no tag
        drive_cycle(1, 1, 8'h05, 8'h7E, 0, 0, 8'h00, 8'h00);
        idle();
        check("rdwr_no_rv", 16'(obs_rv), 16'h0);
        drive_cycle(0, 0, 8'h00, 8'h00, 1, 0, 8'h05, 8'h00);
        idle();
        check("rdwr_readback", 16'(obs_hrd), 16'h007E);

        // Random traffic: requesters hold their request until the model grants it
        h_pend = 0; p_pend = 0;
        h_we = 0; p_rd = 0; p_wr = 0;
        h_addr = 0; h_wd = 0; p_addr = 0; p_wd = 0;
        for (int phase = 0; phase < 3; phase++) begin
            for (int n = 0; n < 600; n++) begin
                if (!h_pend && $urandom_range(0, 99) < 30 + 30 * phase) begin
                    h_pend = 1; h_we = 1'($urandom_range(0, 1));
                    h_addr = 8'($urandom_range(0, 15)); h_wd = 8'($urandom);
                end
                if (!p_pend && $urandom_range(0, 99) < 90 - 25 * phase) begin
                    p_pend = 1;
                    case ($urandom_range(0, 2))
                        0: begin p_rd = 1; p_wr = 0; end
                        1: begin p_rd = 0; p_wr = 1; end
                        default: begin p_rd = 1; p_wr = 1; end
                    endcase
                    p_addr = 8'($urandom_range(0, 15)); p_wd = 8'($urandom);
                end
                drive_cycle(p_pend & p_rd, p_pend & p_wr, p_addr, p_wd, h_pend, h_we, h_addr, h_wd);
                if (m_hg) h_pend = 0;
                if (m_pg) p_pend = 0;
            end
            if (phase == 1) begin
                reset_cycle();
                h_pend = 0; p_pend = 0;
            end
        end
        for (int i = 0; i < RD_LAT + 2; i++) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
